sobel_window_builder: RTL and testbench
=======================================

SOBEL_WINDOW_BUILDER -- requirements
Module: sobel_window_builder

Interface
REQ-001 IMG_W, 32, image width in pixels.
REQ-002 IMG_H, 32, image height in pixels.
REQ-003 PIX_W, 8, pixel data width in bits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  begin a frame; sampled only in IDLE.
REQ-007 pix_valid  input  1  pix_in carries the next raster pixel this cycle.
REQ-008 pix_in  input  PIX_W  pixel data, raster order (row-major, address 0 first).
REQ-009 busy  output  1  high in RUN.
REQ-010 win  output  9*PIX_W  3x3 window, row-major; top-left in MSBs, bottom-right in LSBs.
REQ-011 win_valid  output  1  win and center_addr are valid this cycle (one-cycle pulse per window).
REQ-012 center_addr  output  10  raster address of the window centre (row*IMG_W + col).
REQ-013 done  output  1  one-cycle pulse when the frame completes.

Function
REQ-014 The block SHALL consume the 0..1023 raster pixel stream that the address-generator-driven memory read returns, and emit 3x3 windows for the Sobel core.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE -> RUN SHALL occur when start=1; row and column counters and window registers are cleared on entry.
REQ-017 RUN -> DONE SHALL occur on the cycle the IMG_W*IMG_H-th pixel is accepted.
REQ-018 DONE -> IDLE SHALL occur unconditionally after one cycle; done=1 only in DONE.
REQ-019 A pixel SHALL be accepted only when the state is RUN and pix_valid=1; pix_valid in IDLE or DONE SHALL be ignored.
REQ-020 start in RUN or DONE SHALL be ignored.
REQ-021 Cycles with pix_valid=0 SHALL stall all counters, line buffers and window registers without loss.
REQ-022 The block SHALL keep two line buffers of IMG_W pixels each (rows r-1 and r-2) plus a 3x3 shift register; each accepted pixel shifts one column.
REQ-023 Column counter SHALL wrap IMG_W-1 -> 0 and increment the row counter; the row counter is 5 bits and does not wrap within a frame.
REQ-024 On acceptance of pixel (r,c) with r>=2 and c>=2, win_valid SHALL assert on the next cycle, with the window centred at (r-1,c-1) and center_addr=(r-1)*IMG_W+(c-1).
REQ-025 No window SHALL be emitted for border centres (row 0, row IMG_H-1, col 0, col IMG_W-1); exactly (IMG_W-2)*(IMG_H-2)=900 windows SHALL be emitted per frame.
REQ-026 Column-wrap pixels SHALL never produce a window that mixes pixels from two rows.
REQ-027 win and center_addr SHALL hold their last values when win_valid=0.
REQ-028 The last window (centre addr 990) SHALL assert in the same cycle that done asserts.
REQ-029 center_addr arithmetic SHALL be 10 bits unsigned, with no overflow for 32x32.

Reset
REQ-030 While rst=1, regardless of clk: state=IDLE; busy, win_valid and done = 0; win=0; center_addr=0; counters=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no done is produced for it.
REQ-032 After reset, a new start SHALL restart from address 0.
REQ-033 Line buffer contents need not be cleared by reset but SHALL NOT affect any emitted window.

Verification
REQ-034 Ramp frame, pix_in=addr[7:0], pix_valid=1 continuously -> first win_valid one cycle after pixel 66 is accepted, center_addr=33, win bytes = 0,1,2,32,33,34,64,65,66.
REQ-035 Same frame -> exactly 900 win_valid pulses; none with centre column 0 or 31; last centre=990 with bytes 957,958,959,989,990,991,1021,1022,1023 (each mod 256); done coincident, then IDLE.
REQ-036 Same ramp with pix_valid randomly deasserted (~50%) -> window contents and sequence identical to REQ-034/REQ-035; only the timing stretches.
REQ-037 Assert rst after pixel 500 is accepted, then start a new frame -> no done for the aborted frame; the new frame matches REQ-034 exactly.
REQ-038 pix_valid=1 in IDLE with no start, and start pulsed during RUN -> no windows from the idle data; the frame is not restarted; 900 windows are emitted.

Source files
------------

// File: rtl/sobel_window_builder.sv
// Turns a raster pixel stream into 3x3 windows for the Sobel core.
// Two line buffers hold rows r-1 and r-2; a 3x3 shift register forms the window.
module sobel_window_builder #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_in,
    output logic                 busy,
    output logic [9*PIX_W-1:0]   win,
    output logic                 win_valid,
    output logic [9:0]           center_addr,
    output logic                 done
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [PIX_W-1:0] lb1 [IMG_W];   // row r-1
    logic [PIX_W-1:0] lb2 [IMG_W];   // row r-2
    logic [PIX_W-1:0] w   [3][3];    // [row][col], row 0 = oldest line, col 0 = leftmost

    logic             accept;
    logic             last_col;
    logic             last_pix;
    logic             emit;
    logic [PIX_W-1:0] top_px;
    logic [PIX_W-1:0] mid_px;
    logic [9*PIX_W-1:0] win_next;
    logic [ADDR_W-1:0]  addr_next;

    assign accept   = (state == S_RUN) && pix_valid;
    assign last_col = (col == COL_W'(IMG_W - 1));
    assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));
    // Columns 0 and 1 of a row still hold the previous row's tail, so they never emit.
    assign emit     = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign top_px   = lb2[col];
    assign mid_px   = lb1[col];

    assign win_next = {w[0][1], w[0][2], top_px,
                       w[1][1], w[1][2], mid_px,
                       w[2][1], w[2][2], pix_in};

    assign addr_next = ADDR_W'(row - ROW_W'(1)) * ADDR_W'(IMG_W)
                     + ADDR_W'(col - COL_W'(1));

    // NOTE: line buffers are plain RAM with no reset; rows 0/1 that would expose
    // stale contents are never emitted, so reset logic here would only cost area.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            col         <= '0;
            row         <= '0;
            busy        <= 1'b0;
            win_valid   <= 1'b0;
            done        <= 1'b0;
            win         <= '0;
            center_addr <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] <= '0;
        end else begin
            win_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        col   <= '0;
                        row   <= '0;
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                w[r][c] <= '0;
                    end
                end
                S_RUN: begin
                    if (pix_valid) begin
                        for (int r = 0; r < 3; r++) begin
                            w[r][0] <= w[r][1];
                            w[r][1] <= w[r][2];
                        end
                        w[0][2] <= top_px;
                        w[1][2] <= mid_px;
                        w[2][2] <= pix_in;
                        if (emit) begin
                            win         <= win_next;
                            center_addr <= addr_next;
                            win_valid   <= 1'b1;
                        end
                        if (last_col) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (last_pix) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window_builder.sv
// Self-checking bench for sobel_window_builder: frames are compared against a
// window list computed directly from the image array.
module tb_sobel_window_builder;

    localparam int W = 32;
    localparam int H = 32;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    typedef struct packed {
        logic [9:0]  addr;
        logic [71:0] win;
    } win_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        busy;
    logic [71:0] win;
    logic        win_valid;
    logic [9:0]  center_addr;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int neg_cnt = 0;

    logic [7:0] img [NPIX];
    win_t exp_q [$];
    win_t obs_q [$];
    int   obs_t [$];
    int   done_t [$];

    sobel_window_builder #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .busy        (busy),
        .win         (win),
        .win_valid   (win_valid),
        .center_addr (center_addr),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Outputs are sampled on the falling edge, stamped with the falling-edge index.
    always @(negedge clk) begin
        if (win_valid) begin
            obs_q.push_back({center_addr, win});
            obs_t.push_back(neg_cnt);
        end
        if (done) done_t.push_back(neg_cnt);
        neg_cnt <= neg_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void clear_obs();
        obs_q.delete();
        obs_t.delete();
        done_t.delete();
    endfunction

    function automatic void fill_ramp();
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    endfunction

    // Every interior centre in raster order, window bytes top-left first.
    function automatic void build_expected();
        exp_q.delete();
        for (int cr = 1; cr < H - 1; cr++)
            for (int cc = 1; cc < W - 1; cc++) begin
                win_t e;
                e.addr = 10'(cr * W + cc);
                e.win  = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        e.win = (e.win << 8) | 72'(img[(cr + dr) * W + cc + dc]);
                exp_q.push_back(e);
            end
    endfunction

    task automatic run_frame(input bit stall, input bit inject_start, input int n_px,
                             output int px66_stamp);
        int idx = 0;
        px66_stamp = -1;
        @(negedge clk); #1;
        start = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        while (idx < n_px) begin
            if (stall && $urandom_range(1) == 0) begin
                pix_valid = 1'b0;
                pix_in = 8'($urandom);
            end else begin
                pix_valid = 1'b1;
                pix_in = img[idx];
                if (idx == 66) px66_stamp = neg_cnt;
                idx++;
            end
            start = inject_start && (idx < NPIX - 8) && ($urandom_range(7) == 0);
            @(negedge clk); #1;
        end
        pix_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int px66_stamp);
        int n;
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if (obs_q.size() !== NWIN) begin
            n_err++;
            $display("FAIL %s win_count: got %0d, expected %0d", tag, obs_q.size(), NWIN);
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s window[%0d]: got addr=%0d win=%h, expected addr=%0d win=%h",
                         tag, i, obs_q[i].addr, obs_q[i].win, exp_q[i].addr, exp_q[i].win);
            end
        end
        n_vec++;
        if (done_t.size() !== 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d, expected 1", tag, done_t.size());
        end else if (obs_t.size() > 0) begin
            n_vec++;
            if (done_t[0] !== obs_t[obs_t.size() - 1]) begin
                n_err++;
                $display("FAIL %s done_align: done at %0d, last window at %0d",
                         tag, done_t[0], obs_t[obs_t.size() - 1]);
            end
        end
        if (obs_t.size() > 0) begin
            n_vec++;
            if (obs_t[0] !== px66_stamp) begin
                n_err++;
                $display("FAIL %s first_win_timing: got stamp %0d, expected %0d",
                         tag, obs_t[0], px66_stamp);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_after: busy=%b done=%b, expected 0 0", tag, busy, done);
        end
        clear_obs();
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (busy !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0 ||
            win !== 72'd0 || center_addr !== 10'd0) begin
            n_err++;
            $display("FAIL %s reset_outputs: busy=%b win_valid=%b done=%b win=%h addr=%0d, expected all 0",
                     tag, busy, win_valid, done, win, center_addr);
        end
    endtask

    task automatic test_reset();
        #3;
        check_reset_outputs("test_reset");
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("test_reset_clocked");
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic test_ramp();
        int s66;
        fill_ramp();
        build_expected();
        n_vec++;
        if (exp_q[0].addr !== 10'd33 || exp_q[NWIN - 1].addr !== 10'd990) begin
            n_err++;
            $display("FAIL test_ramp model_ends: got %0d/%0d, expected 33/990",
                     exp_q[0].addr, exp_q[NWIN - 1].addr);
        end
        run_frame(1'b0, 1'b0, NPIX, s66);
        check_frame("test_ramp", s66);
    endtask

    task automatic test_stall();
        int s66;
        fill_ramp();
        build_expected();
        run_frame(1'b1, 1'b0, NPIX, s66);
        check_frame("test_stall", s66);
    endtask

    task automatic test_random_data();
        int s66;
        fill_random();
        build_expected();
        run_frame(1'b1, 1'b0, NPIX, s66);
        check_frame("test_random_data", s66);
    endtask

    task automatic test_abort();
        int s66;
        fill_ramp();
        build_expected();
        run_frame(1'b0, 1'b0, 501, s66);
        rst = 1'b1;
        #1;
        check_reset_outputs("test_abort");
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if (done_t.size() !== 0) begin
            n_err++;
            $display("FAIL test_abort no_done: got %0d done pulses, expected 0", done_t.size());
        end
        clear_obs();
        run_frame(1'b0, 1'b0, NPIX, s66);
        check_frame("test_abort_restart", s66);
    endtask

    task automatic test_ignored_inputs();
        int s66;
        fill_ramp();
        build_expected();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            pix_valid = 1'b1;
            pix_in = 8'($urandom);
        end
        @(negedge clk); #1;
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (obs_q.size() !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL test_idle_data: got %0d windows busy=%b, expected 0 windows busy=0",
                     obs_q.size(), busy);
        end
        clear_obs();
        run_frame(1'b1, 1'b1, NPIX, s66);
        check_frame("test_start_in_run", s66);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_random_data();
        test_abort();
        test_ignored_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
